mac_receive: RTL and testbench

MAC_RECEIVE -- requirements
Module: mac_receive

---
 rtl/mac_receive.sv | 202 ++++++++++++++++++++
 tb/tb_mac_receive.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_receive.sv
// mac_receive: RMII receiver doing preamble/SFD hunt, byte assembly, destination filter and FCS check.
// Latency: a byte leaves on data_out when the 4th later byte completes (FCS never emitted); frame_done 2 clocks after carrier end.
// No backpressure: data_valid_out is a one-cycle strobe the consumer must take; frame verdict is held until the next frame_done.
module mac_receive #(
  parameter logic [47:0] MAC_ADDR    = 48'h02_00_00_00_00_01,
  parameter bit          PROMISCUOUS = 1'b0,
  parameter int          MAX_FRAME   = 1518
) (
  input  logic        clk_100mhz,
  input  logic        rstn,
  input  logic        eth_refclk,
  input  logic        eth_crsdv,
  input  logic [1:0]  eth_rxd,
  output logic [7:0]  data_out,
  output logic        data_valid_out,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [10:0] frame_len,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  localparam logic [11:0] MAX_LEN     = 12'(MAX_FRAME);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  // Reflected CRC-32 update over one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  logic            crs_q, crs_prev_q, smp_q;
  logic [1:0]      rxd_q;
  state_t          state_q;
  logic            seen01_q, from_data_q;
  logic [5:0]      sh_q;
  logic [1:0]      dcnt_q;
  logic [10:0]     cnt_q;
  logic [31:0]     crc_q;
  logic [3:0][7:0] line_q;
  logic [2:0]      fill_q;
  logic            dst_u_q, dst_b_q;
  logic            done_pend_q, ok_pend_q;

  logic [7:0]      byte_d, mac_byte;
  logic [47:0]     mac_sh;
  logic [31:0]     crc_d;
  logic [10:0]     cnt_d;
  logic            over_d, in_dst, dst_u_d, dst_b_d, verdict_d, valid, car_end;

  assign valid   = crs_q | crs_prev_q;
  assign car_end = !crs_q && !crs_prev_q;
  assign busy    = (state_q != IDLE);

  // Register RMII pins only on refclk-high cycles; smp_q flags the cycle that processes the sample.
  always_ff @(posedge clk_100mhz or negedge rstn) begin
    if (!rstn) begin
      crs_q      <= 1'b0;
      crs_prev_q <= 1'b0;
      rxd_q      <= 2'b00;
      smp_q      <= 1'b0;
    end else begin
      smp_q <= eth_refclk;
      if (eth_refclk) begin
        crs_q      <= eth_crsdv;
        crs_prev_q <= crs_q;
        rxd_q      <= eth_rxd;
      end
    end
  end

  // Next-byte, CRC, count, destination-match and verdict terms for the current sample.
  always_comb begin
    byte_d    = {rxd_q, sh_q};
    crc_d     = crc_byte(crc_q, byte_d);
    cnt_d     = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
    over_d    = ({1'b0, cnt_q} + 12'd1) > MAX_LEN;
    mac_sh    = MAC_ADDR << {cnt_q[2:0], 3'b000};
    mac_byte  = mac_sh[47:40];
    in_dst    = cnt_q < 11'd6;
    dst_u_d   = dst_u_q & (!in_dst | (byte_d == mac_byte));
    dst_b_d   = dst_b_q & (!in_dst | (byte_d == 8'hFF));
    verdict_d = (crc_q == CRC_RESIDUE) && (PROMISCUOUS || dst_u_q || dst_b_q) &&
                (cnt_q >= 11'd64) && ({1'b0, cnt_q} <= MAX_LEN) && (dcnt_q <= 2'd1);
  end

  // Receive FSM with registered outputs; the verdict is staged one cycle so frame_done lands 2 clocks after the end strobe.
  always_ff @(posedge clk_100mhz or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      seen01_q       <= 1'b0;
      from_data_q    <= 1'b0;
      sh_q           <= '0;
      dcnt_q         <= '0;
      cnt_q          <= '0;
      crc_q          <= '0;
      line_q         <= '0;
      fill_q         <= '0;
      dst_u_q        <= 1'b0;
      dst_b_q        <= 1'b0;
      done_pend_q    <= 1'b0;
      ok_pend_q      <= 1'b0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      frame_start    <= 1'b0;
      frame_done     <= 1'b0;
      frame_ok       <= 1'b0;
      frame_len      <= '0;
    end else begin
      data_valid_out <= 1'b0;
      frame_start    <= 1'b0;
      frame_done     <= 1'b0;
      if (done_pend_q) begin
        done_pend_q <= 1'b0;
        frame_done  <= 1'b1;
        frame_ok    <= ok_pend_q;
        frame_len   <= cnt_q;
      end
      if (smp_q) begin
        case (state_q)
          IDLE: begin
            if (crs_q) begin
              state_q  <= PREAMBLE;
              seen01_q <= (rxd_q == 2'b01);
            end
          end
          PREAMBLE: begin
            if (car_end) begin
              state_q <= IDLE;
            end else begin
              case (rxd_q)
                2'b01: seen01_q <= 1'b1;
                2'b11: begin
                  if (seen01_q) begin
                    state_q     <= DATA;
                    frame_start <= 1'b1;
                    dcnt_q      <= '0;
                    cnt_q       <= '0;
                    crc_q       <= 32'hFFFF_FFFF;
                    fill_q      <= '0;
                    dst_u_q     <= 1'b1;
                    dst_b_q     <= 1'b1;
                  end else begin
                    state_q     <= DROP;
                    from_data_q <= 1'b0;
                  end
                end
                2'b10: begin
                  state_q     <= DROP;
                  from_data_q <= 1'b0;
                end
                default: ;
              endcase
            end
          end
          DATA: begin
            if (car_end) begin
              state_q     <= IDLE;
              done_pend_q <= 1'b1;
              ok_pend_q   <= verdict_d;
            end else if (valid) begin
              sh_q   <= {rxd_q, sh_q[5:2]};
              dcnt_q <= dcnt_q + 2'd1;
              if (dcnt_q == 2'd3) begin
                crc_q   <= crc_d;
                cnt_q   <= cnt_d;
                dst_u_q <= dst_u_d;
                dst_b_q <= dst_b_d;
                line_q  <= {line_q[2:0], byte_d};
                if (fill_q == 3'd4) begin
                  data_out       <= line_q[3];
                  data_valid_out <= 1'b1;
                end else begin
                  fill_q <= fill_q + 3'd1;
                end
                if (over_d || (cnt_q == 11'd5 && !PROMISCUOUS && !dst_u_d && !dst_b_d)) begin
                  state_q     <= DROP;
                  from_data_q <= 1'b1;
                end
              end
            end
          end
          DROP: begin
            if (car_end) begin
              state_q <= IDLE;
              if (from_data_q) begin
                done_pend_q <= 1'b1;
                ok_pend_q   <= 1'b0;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_receive.sv
// tb_mac_receive: directed RMII frames into a filtering and a promiscuous receiver.
// Expected bytes are queued as frames are driven and popped as data_valid_out strobes arrive.
// Frame verdicts, lengths, strobe counts and reset behaviour are checked after each frame.
module tb_mac_receive;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rstn, refclk, crsdv;
  logic [1:0]  rxd;
  logic [7:0]  dout1, dout2;
  logic        dv1, fs1, fd1, ok1, busy1;
  logic        dv2, fs2, fd2, ok2, busy2;
  logic [10:0] len1, len2;

  int   n_chk = 0, n_pass = 0, n_fail = 0;
  int   n_strb = 0, n_start = 0, n_done = 0, n_done2 = 0;
  logic last_ok = 1'b0, last_ok2 = 1'b0;
  logic [10:0] last_len = '0;
  bit   ign = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  mac_receive #(.PROMISCUOUS(1'b0)) u_dut (
    .clk_100mhz(clk), .rstn(rstn), .eth_refclk(refclk), .eth_crsdv(crsdv), .eth_rxd(rxd),
    .data_out(dout1), .data_valid_out(dv1), .frame_start(fs1), .frame_done(fd1),
    .frame_ok(ok1), .frame_len(len1), .busy(busy1));

  mac_receive #(.PROMISCUOUS(1'b1)) u_prom (
    .clk_100mhz(clk), .rstn(rstn), .eth_refclk(refclk), .eth_crsdv(crsdv), .eth_rxd(rxd),
    .data_out(dout2), .data_valid_out(dv2), .frame_start(fs2), .frame_done(fd2),
    .frame_ok(ok2), .frame_len(len2), .busy(busy2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest queued byte.
  always @(negedge clk) begin
    if (dv1 === 1'b1) begin
      n_strb++;
      if (!ign) begin
        check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("data_out", 32'(dout1), 32'(exp_q.pop_front()));
      end
    end
    if (fs1 === 1'b1) n_start++;
    if (fd1 === 1'b1) begin
      n_done++;
      last_ok  = ok1;
      last_len = len1;
    end
    if (fd2 === 1'b1) begin
      n_done2++;
      last_ok2 = ok2;
    end
  end

  function automatic logic [31:0] crc32(input bq_t q);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < q.size(); i++)
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ q[i][j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return c;
  endfunction

  task automatic build(input logic [47:0] dst, input int len, input bit bad, output bq_t fr);
    logic [47:0] src;
    logic [31:0] fcs;
    logic [7:0]  b;
    src = 48'h02_00_00_00_00_99;
    fr  = {};
    for (int i = 0; i < 6; i++) fr.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(src[47-8*i -: 8]);
    fr.push_back(8'h08);
    fr.push_back(8'h00);
    while (fr.size() < len - 4) begin
      b = 8'((fr.size() * 37 + 11) & 255);
      fr.push_back(b);
    end
    fcs = ~crc32(fr);
    for (int k = 0; k < 4; k++) fr.push_back(fcs[8*k +: 8]);
    if (bad) fr[len-1] = fr[len-1] ^ 8'h08;
  endtask

  task automatic send_dibit(input logic c, input logic [1:0] d);
    @(posedge clk); #1;
    refclk = 1'b1; crsdv = c; rxd = d;
    @(posedge clk); #1;
    refclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [3:0] cm);
    for (int i = 0; i < 4; i++) send_dibit(cm[i], b[2*i +: 2]);
  endtask

  task automatic send_preamble();
    for (int i = 0; i < 7; i++) send_byte(8'h55, 4'hF);
    send_byte(8'hD5, 4'hF);
  endtask

  // mode 0: clean end; mode 1: crsdv toggles over last byte; mode 2: two trailing dibits.
  task automatic send_frame(input bq_t fr, input int mode);
    send_preamble();
    for (int i = 0; i < fr.size() - 1; i++) send_byte(fr[i], 4'hF);
    send_byte(fr[fr.size()-1], (mode == 1) ? 4'b1010 : 4'hF);
    if (mode == 2) send_dibit(1'b1, 2'b10);
    send_dibit(1'b0, 2'b01);
    for (int i = 0; i < 5; i++) send_dibit(1'b0, 2'b00);
  endtask

  task automatic run(input string tag, input bq_t fr, input int mode, input int n_exp,
                     input int exp_strb, input logic exp_ok, input int exp_len);
    int s0, d0, b0;
    s0 = n_start; d0 = n_done; b0 = n_strb;
    for (int i = 0; i < n_exp; i++) exp_q.push_back(fr[i]);
    send_frame(fr, mode);
    check({tag, "_start"}, 32'(n_start - s0), 32'd1);
    check({tag, "_done"}, 32'(n_done - d0), 32'd1);
    check({tag, "_ok"}, 32'(last_ok), 32'(exp_ok));
    if (exp_strb >= 0) check({tag, "_strobes"}, 32'(n_strb - b0), 32'(exp_strb));
    if (exp_len >= 0) check({tag, "_len"}, 32'(last_len), 32'(exp_len));
    check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy"}, 32'(busy1), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_data_out"}, 32'(dout1), 32'd0);
    check({tag, "_dv"}, 32'(dv1), 32'd0);
    check({tag, "_fstart"}, 32'(fs1), 32'd0);
    check({tag, "_fdone"}, 32'(fd1), 32'd0);
    check({tag, "_fok"}, 32'(ok1), 32'd0);
    check({tag, "_flen"}, 32'(len1), 32'd0);
    check({tag, "_busy"}, 32'(busy1), 32'd0);
  endtask

  initial begin
    bq_t fr;
    int  d0, d20, b0, s0;
    rstn = 1'b0; refclk = 1'b0; crsdv = 1'b0; rxd = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rstn = 1'b1;
    repeat (4) @(posedge clk);

    build(48'hFF_FF_FF_FF_FF_FF, 64, 1'b0, fr);
    run("bcast_good", fr, 0, 60, 60, 1'b1, 64);

    build(48'hFF_FF_FF_FF_FF_FF, 64, 1'b1, fr);
    run("bcast_badfcs", fr, 0, 60, 60, 1'b0, 64);

    d20 = n_done2;
    build(48'h02_00_00_00_00_02, 64, 1'b0, fr);
    run("ucast_filter", fr, 0, 2, 2, 1'b0, -1);
    check("ucast_prom_done", 32'(n_done2 - d20), 32'd1);
    check("ucast_prom_ok", 32'(last_ok2), 32'd1);

    build(48'h02_00_00_00_00_01, 72, 1'b0, fr);
    run("own_addr", fr, 0, 68, 68, 1'b1, 72);

    build(48'hFF_FF_FF_FF_FF_FF, 64, 1'b0, fr);
    run("toggle_1dibit", fr, 1, 60, 60, 1'b1, 64);
    run("trail_2dibit", fr, 2, 60, 60, 1'b0, 64);

    fr = {};
    for (int i = 0; i < 3; i++) fr.push_back(8'hFF);
    run("short3", fr, 0, 0, 0, 1'b0, 3);

    // Bad preamble (dibit 10) must neither start nor finish a frame.
    s0 = n_start; d0 = n_done; b0 = n_strb;
    for (int i = 0; i < 3; i++) send_dibit(1'b1, 2'b01);
    send_dibit(1'b1, 2'b10);
    for (int i = 0; i < 8; i++) send_dibit(1'b1, 2'b01);
    send_dibit(1'b1, 2'b11);
    for (int i = 0; i < 16; i++) send_dibit(1'b1, 2'b10);
    for (int i = 0; i < 4; i++) send_dibit(1'b0, 2'b00);
    check("badpre_start", 32'(n_start - s0), 32'd0);
    check("badpre_done", 32'(n_done - d0), 32'd0);
    check("badpre_strobes", 32'(n_strb - b0), 32'd0);
    check("badpre_busy", 32'(busy1), 32'd0);

    // Reset in the middle of DATA.
    ign = 1'b1;
    build(48'hFF_FF_FF_FF_FF_FF, 64, 1'b0, fr);
    d0 = n_done;
    send_preamble();
    for (int i = 0; i < 20; i++) send_byte(fr[i], 4'hF);
    @(posedge clk); @(posedge clk); #1;
    check("midrst_busy_before", 32'(busy1), 32'd1);
    rstn = 1'b0; crsdv = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) send_dibit(1'b0, 2'b00);
    check("midrst_no_done", 32'(n_done - d0), 32'd0);
    check("midrst_busy_after", 32'(busy1), 32'd0);
    exp_q.delete();
    ign = 1'b0;

    build(48'hFF_FF_FF_FF_FF_FF, 64, 1'b0, fr);
    run("after_rst", fr, 0, 60, 60, 1'b1, 64);

    ign = 1'b1;
    build(48'hFF_FF_FF_FF_FF_FF, 1600, 1'b0, fr);
    run("oversize", fr, 0, 0, -1, 1'b0, -1);
    check("oversize_len_min", 32'(last_len >= 11'd1519), 32'd1);
    ign = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
